// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} pairs with a single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop_s  = pop && !flush && (count_q != {CW{1'b0}});
        // A full queue still takes a push when the head leaves on the same edge.
        do_push_s = push && !flush && ((count_q != FULL) || do_pop_s);
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, one in-flight memory read, decoupling
// queue towards the decoder, and redirect handling through a one-cycle FLUSH.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [WORD_W-1:0] imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_L = CW1'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pending_q, pending_d;
    logic [CW-1:0]     count_s;
    logic [CW:0]       inflight_s;
    logic              issue_s, push_s, pop_s, flush_s;
    fetch_entry_t      push_data_s, head_s;

    // Queued plus in-flight words must never exceed the queue size.
    assign inflight_s  = {1'b0, count_s} + {{CW{1'b0}}, pending_q};
    assign push_data_s = '{instr: imem_instr, pc: pend_pc_q};
    assign pop_s       = out_valid && out_ready;

    // Next-state, fetch issue and queue control.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pending_d = pending_q;
        issue_s   = 1'b0;
        push_s    = 1'b0;
        flush_s   = 1'b0;
        case (state_q)
            BOOT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                issue_s = (inflight_s < DEPTH_L);
                if (redirect_valid) begin
                    // The returning word and anything issued this cycle are dropped.
                    flush_s   = 1'b1;
                    pending_d = 1'b0;
                    pc_d      = redirect_pc;
                    state_d   = FLUSH;
                end else begin
                    push_s = pending_q;
                    if (issue_s) begin
                        pending_d = 1'b1;
                        pend_pc_d = pc_q;
                        pc_d      = pc_q + 16'h0001;
                    end else begin
                        pending_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                pending_d = 1'b0;
                if (redirect_valid) begin
                    flush_s = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                flush_s   = 1'b1;
                pending_d = 1'b0;
                pc_d      = RESET_PC;
                state_d   = BOOT;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= 16'h0000;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pending_q <= pending_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push_s),
        .push_data(push_data_s),
        .pop      (pop_s),
        .flush    (flush_s),
        .head     (head_s),
        .count    (count_s)
    );

    assign imem_addr = pc_q;
    assign imem_req  = issue_s;
    assign out_valid = (count_s != {CW{1'b0}});
    assign out_instr = out_valid ? head_s.instr : 16'h0000;
    assign out_pc    = out_valid ? head_s.pc : 16'h0000;

endmodule
